serializer_rd_fsm: RTL and testbench

AXI4 read-channel slave for the protobuf serializer: the read-side counterpart of the write FSM that loads the varint and raw-data input FIFOs. It accepts AR requests from the HPS bridge. Reads of the output window pop serialized 32-bit words from the serializer output FIFO. Reads of the status window return FIFO flags and fill level. A programmable empty-timeout keeps a starved burst from hanging the bus.

---
 rtl/serializer_pkg.sv | 64 ++++++
 rtl/serializer_rd_fsm_rd_timeout_ctr.sv | 35 +++
 rtl/serializer_rd_fsm.sv | 172 +++++++++++++++++
 tb/tb_serializer_rd_fsm.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the protobuf serializer AXI read slave: FSM
// encodings, address windows, response codes and status-word layout.
package serializer_pkg;

  // One-hot read FSM states.
  typedef enum logic [4:0] {
    ST_INIT     = 5'b00001,
    ST_AR_READY = 5'b00010,
    ST_FETCH    = 5'b00100,
    ST_LOAD     = 5'b01000,
    ST_R_VALID  = 5'b10000
  } rd_state_e;

  // Decoded target of a read burst.
  typedef enum logic [1:0] {
    WIN_SEL_DATA   = 2'd0,
    WIN_SEL_STATUS = 2'd1,
    WIN_SEL_ERR    = 2'd2
  } win_sel_e;

  // araddr[15:8] values selecting each window.
  localparam logic [7:0] WIN_DATA   = 8'h05;
  localparam logic [7:0] WIN_STATUS = 8'h06;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Only full 32-bit beats are supported.
  localparam logic [2:0] SIZE_WORD = 3'b010;

  // Status-word bit positions.
  localparam int STAT_EMPTY_BIT       = 0;
  localparam int STAT_VARINT_FULL_BIT = 1;
  localparam int STAT_RAW_FULL_BIT    = 2;
  localparam int STAT_COUNT_LSB       = 16;
  localparam int STAT_COUNT_W         = 10;

  // Map an AR request onto a window; bad size always lands in ERR.
  function automatic win_sel_e decode_window(input logic [15:0] addr,
                                             input logic [2:0]  size);
    win_sel_e w;
    w = WIN_SEL_ERR;
    if (size == SIZE_WORD) begin
      if (addr[15:8] == WIN_DATA)        w = WIN_SEL_DATA;
      else if (addr[15:8] == WIN_STATUS) w = WIN_SEL_STATUS;
    end
    return w;
  endfunction

  // Assemble the status word from FIFO flags and fill level.
  function automatic logic [31:0] status_word(input logic [STAT_COUNT_W-1:0] count,
                                              input logic raw_full,
                                              input logic varint_full,
                                              input logic empty);
    logic [31:0] s;
    s = '0;
    s[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    s[STAT_RAW_FULL_BIT]              = raw_full;
    s[STAT_VARINT_FULL_BIT]           = varint_full;
    s[STAT_EMPTY_BIT]                 = empty;
    return s;
  endfunction

endpackage

// File: rtl/serializer_rd_fsm_rd_timeout_ctr.sv
// Empty-FIFO wait counter: counts enabled cycles, clears on demand and
// flags the last cycle before the programmed limit is reached.
// LIMIT = 0 disables the terminal count (wait forever).
module rd_timeout_ctr #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] cnt;

  // Wait counter: clear has priority; counting is frozen when disabled.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (LIMIT != 0)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Terminal count on the cycle where the count reaches LIMIT-1.
  always_comb begin
    tc = 1'b0;
    if (LIMIT != 0) begin
      tc = en && (cnt == CW'(LIMIT - 1));
    end
  end

endmodule

// File: rtl/serializer_rd_fsm.sv
// AXI4 read-channel slave for the protobuf serializer. DATA window reads
// pop the output FIFO one word per beat, STATUS window reads return FIFO
// flags/fill level, anything else answers SLVERR. An empty-FIFO timeout
// turns a starved beat into an SLVERR beat instead of stalling the bus.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never waits on ready, and rdata/rresp/rid/rlast hold
// steady while rvalid is high and rready is low.
module serializer_rd_fsm
  import serializer_pkg::*;
#(
  parameter int EMPTY_TIMEOUT = 1023,
  parameter int CNT_W         = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       axs_s0_arid,
  input  logic [15:0]      axs_s0_araddr,
  input  logic [7:0]       axs_s0_arlen,
  input  logic [2:0]       axs_s0_arsize,
  input  logic [1:0]       axs_s0_arburst,
  input  logic             axs_s0_arvalid,
  output logic             axs_s0_arready,
  output logic [3:0]       axs_s0_rid,
  output logic [31:0]      axs_s0_rdata,
  output logic [1:0]       axs_s0_rresp,
  output logic             axs_s0_rlast,
  output logic             axs_s0_rvalid,
  input  logic             axs_s0_rready,
  input  logic             out_fifo_empty,
  input  logic [31:0]      out_fifo_data,
  input  logic [CNT_W-1:0] out_fifo_count,
  output logic             out_fifo_pop,
  output logic             out_fifo_clr,
  input  logic             varint_in_fifo_full,
  input  logic             raw_data_in_fifo_full,
  output rd_state_e        state_dbg
);

  rd_state_e   state, state_d;
  win_sel_e    win_q;
  logic [3:0]  rid_q;
  logic [7:0]  beats_left;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        ar_fire;
  logic        dec_beat;
  logic        cap_en;
  logic [31:0] cap_data;
  logic [1:0]  cap_resp;
  win_sel_e    ar_win;
  logic        tmo_tc;
  logic [STAT_COUNT_W-1:0] count10;

  // Burst type and the in-window byte offset do not affect the response.
  logic unused_bits;
  assign unused_bits = ^{axs_s0_arburst, axs_s0_araddr[7:0]};

  assign ar_win  = decode_window(axs_s0_araddr, axs_s0_arsize);
  assign count10 = STAT_COUNT_W'(out_fifo_count);

  rd_timeout_ctr #(
    .LIMIT (EMPTY_TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .en    ((state == ST_FETCH) && out_fifo_empty),
    .clr   (state != ST_FETCH),
    .tc    (tmo_tc)
  );

  // State register plus latched request fields and the registered R beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      win_q      <= WIN_SEL_ERR;
      rid_q      <= '0;
      beats_left <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      state <= state_d;
      if (state == ST_INIT) begin
        win_q      <= WIN_SEL_ERR;
        rid_q      <= '0;
        beats_left <= '0;
        rdata_q    <= '0;
        rresp_q    <= RESP_OKAY;
      end
      if (ar_fire) begin
        win_q      <= ar_win;
        rid_q      <= axs_s0_arid;
        beats_left <= axs_s0_arlen;
      end
      if (dec_beat) begin
        beats_left <= beats_left - 8'd1;
      end
      if (cap_en) begin
        rdata_q <= cap_data;
        rresp_q <= cap_resp;
      end
    end
  end

  // Next-state logic, FIFO pop/clear strobes and beat capture selection.
  always_comb begin
    state_d      = state;
    out_fifo_pop = 1'b0;
    out_fifo_clr = 1'b0;
    ar_fire      = 1'b0;
    dec_beat     = 1'b0;
    cap_en       = 1'b0;
    cap_data     = '0;
    cap_resp     = RESP_OKAY;
    case (state)
      ST_INIT: begin
        out_fifo_clr = 1'b1;
        state_d      = ST_AR_READY;
      end
      ST_AR_READY: begin
        if (axs_s0_arvalid) begin
          ar_fire = 1'b1;
          state_d = (ar_win == WIN_SEL_DATA) ? ST_FETCH : ST_LOAD;
        end
      end
      ST_FETCH: begin
        if (!out_fifo_empty) begin
          out_fifo_pop = 1'b1;
          cap_en       = 1'b1;
          cap_data     = out_fifo_data;
          state_d      = ST_R_VALID;
        end else if (tmo_tc) begin
          // Starved beat: answer with an error, the burst itself continues.
          cap_en   = 1'b1;
          cap_resp = RESP_SLVERR;
          state_d  = ST_R_VALID;
        end
      end
      ST_LOAD: begin
        cap_en = 1'b1;
        if (win_q == WIN_SEL_STATUS) begin
          cap_data = status_word(count10, raw_data_in_fifo_full,
                                 varint_in_fifo_full, out_fifo_empty);
        end else begin
          cap_resp = RESP_SLVERR;
        end
        state_d = ST_R_VALID;
      end
      ST_R_VALID: begin
        if (axs_s0_rready) begin
          if (beats_left == 8'd0) begin
            state_d = ST_AR_READY;
          end else begin
            dec_beat = 1'b1;
            state_d  = (win_q == WIN_SEL_DATA) ? ST_FETCH : ST_LOAD;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign axs_s0_arready = (state == ST_AR_READY);
  assign axs_s0_rvalid  = (state == ST_R_VALID);
  assign axs_s0_rlast   = (state == ST_R_VALID) && (beats_left == 8'd0);
  assign axs_s0_rid     = rid_q;
  assign axs_s0_rdata   = rdata_q;
  assign axs_s0_rresp   = rresp_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_serializer_rd_fsm.sv
// Directed bench for serializer_rd_fsm: a behavioural show-ahead output
// FIFO, an AR driver, an R-beat scoreboard and a final report.
module tb_serializer_rd_fsm;
  import serializer_pkg::*;

  localparam int CNT_W = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [3:0]       arid = '0;
  logic [15:0]      araddr = '0;
  logic [7:0]       arlen = '0;
  logic [2:0]       arsize = '0;
  logic [1:0]       arburst = '0;
  logic             arvalid = 1'b0;
  logic             arready;
  logic [3:0]       rid;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rlast;
  logic             rvalid;
  logic             rready = 1'b0;
  logic             out_fifo_empty = 1'b1;
  logic [31:0]      out_fifo_data = '0;
  logic [CNT_W-1:0] out_fifo_count = '0;
  logic             out_fifo_pop;
  logic             out_fifo_clr;
  logic             varint_full = 1'b0;
  logic             raw_full = 1'b0;
  rd_state_e        state_dbg;

  serializer_rd_fsm #(
    .EMPTY_TIMEOUT (8),
    .CNT_W         (CNT_W)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .axs_s0_arid           (arid),
    .axs_s0_araddr         (araddr),
    .axs_s0_arlen          (arlen),
    .axs_s0_arsize         (arsize),
    .axs_s0_arburst        (arburst),
    .axs_s0_arvalid        (arvalid),
    .axs_s0_arready        (arready),
    .axs_s0_rid            (rid),
    .axs_s0_rdata          (rdata),
    .axs_s0_rresp          (rresp),
    .axs_s0_rlast          (rlast),
    .axs_s0_rvalid         (rvalid),
    .axs_s0_rready         (rready),
    .out_fifo_empty        (out_fifo_empty),
    .out_fifo_data         (out_fifo_data),
    .out_fifo_count        (out_fifo_count),
    .out_fifo_pop          (out_fifo_pop),
    .out_fifo_clr          (out_fifo_clr),
    .varint_in_fifo_full   (varint_full),
    .raw_data_in_fifo_full (raw_full),
    .state_dbg             (state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // ---------------- output FIFO model ----------------
  logic [31:0] fifo_q[$];
  int          pop_cnt = 0;
  logic        pend_pop = 1'b0;
  logic        pend_clr = 1'b0;

  task automatic fifo_refresh();
    out_fifo_empty = (fifo_q.size() == 0);
    out_fifo_data  = (fifo_q.size() == 0) ? 32'hDEAD_BEEF : fifo_q[0];
    out_fifo_count = CNT_W'(fifo_q.size());
  endtask

  task automatic fifo_push(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_refresh();
  endtask

  task automatic fifo_flush();
    fifo_q.delete();
    fifo_refresh();
  endtask

  // Sample strobes mid-cycle, once all inputs have settled.
  always @(negedge clk) begin
    #1;
    pend_pop = out_fifo_pop;
    pend_clr = out_fifo_clr;
  end

  // Apply pop/clear just after the edge so the DUT sees the old head word.
  always @(posedge clk) begin
    #1;
    if (pend_clr) begin
      fifo_q.delete();
    end else if (pend_pop) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pop_cnt++;
    end
    fifo_refresh();
  end

  // ---------------- R scoreboard ----------------
  logic [63:0] exp_q[$];

  function automatic logic [63:0] beat(input logic [3:0] id, input logic [1:0] resp,
                                       input logic last, input logic [31:0] data);
    return {25'b0, id, resp, last, data};
  endfunction

  always @(negedge clk) begin
    #1;
    if (!reset && rvalid && rready) begin
      if (exp_q.size() == 0) check("unexpected_beat", beat(rid, rresp, rlast, rdata), 64'h0);
      else check("r_beat", beat(rid, rresp, rlast, rdata), exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ar_req(input logic [3:0] id, input logic [15:0] addr,
                        input logic [7:0] len, input logic [2:0] size);
    int n;
    n = 0;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size;
    arburst = 2'b01; arvalid = 1'b1;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ar_accept_timeout", 64'(n), 64'h0);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !arready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'h0);
    exp_q.delete();
  endtask

  task automatic wait_rvalid();
    int n;
    n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rvalid_seen", 64'(rvalid), 64'h1);
  endtask

  // ---------------- directed tests ----------------
  int p0;
  int clr_seen;
  int cnt;

  initial begin
    // Reset with a stale word sitting in the FIFO.
    fifo_push(32'hA5A5_0001);
    repeat (3) @(negedge clk);
    check("rst_arready", 64'(arready), 64'h0);
    check("rst_rvalid",  64'(rvalid),  64'h0);
    check("rst_rlast",   64'(rlast),   64'h0);
    check("rst_rdata",   64'(rdata),   64'h0);
    check("rst_rresp",   64'(rresp),   64'h0);
    check("rst_rid",     64'(rid),     64'h0);
    check("rst_pop",     64'(out_fifo_pop), 64'h0);

    // Release: one INIT cycle with clr, then AR_READY.
    reset = 1'b0;
    clr_seen = 0;
    if (out_fifo_clr) clr_seen++;
    check("init_arready", 64'(arready), 64'h0);
    @(negedge clk);
    check("ready_after_init", 64'(arready), 64'h1);
    repeat (3) begin
      if (out_fifo_clr) clr_seen++;
      @(negedge clk);
    end
    check("clr_pulses", 64'(clr_seen), 64'h1);
    check("fifo_cleared", 64'(out_fifo_count), 64'h0);

    // DATA burst of 4, rready held high.
    rready = 1'b1;
    fifo_push(32'h11); fifo_push(32'h22); fifo_push(32'h33); fifo_push(32'h44);
    exp_q.push_back(beat(4'h1, RESP_OKAY, 1'b0, 32'h11));
    exp_q.push_back(beat(4'h1, RESP_OKAY, 1'b0, 32'h22));
    exp_q.push_back(beat(4'h1, RESP_OKAY, 1'b0, 32'h33));
    exp_q.push_back(beat(4'h1, RESP_OKAY, 1'b1, 32'h44));
    p0 = pop_cnt;
    ar_req(4'h1, 16'h0500, 8'd3, 3'b010);
    check("fetch_pop", 64'(out_fifo_pop), 64'h1);
    @(negedge clk);
    check("first_rvalid", 64'(rvalid), 64'h1);
    wait_drain("data4_drain");
    check("data4_pops", 64'(pop_cnt - p0), 64'h4);

    // DATA single beat on an empty FIFO: times out after 8 FETCH cycles.
    exp_q.push_back(beat(4'h7, RESP_SLVERR, 1'b1, 32'h0));
    p0 = pop_cnt;
    ar_req(4'h7, 16'h0504, 8'd0, 3'b010);
    cnt = 0;
    while (!rvalid && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_cycles", 64'(cnt), 64'h8);
    wait_drain("timeout_drain");
    check("timeout_no_pop", 64'(pop_cnt - p0), 64'h0);

    // STATUS read: 5 words queued, varint FIFO full.
    varint_full = 1'b1;
    repeat (5) fifo_push(32'h5555_0000);
    exp_q.push_back(beat(4'h3, RESP_OKAY, 1'b1, 32'h0005_0002));
    p0 = pop_cnt;
    ar_req(4'h3, 16'h0600, 8'd0, 3'b010);
    wait_drain("status_drain");
    check("status_no_pop", 64'(pop_cnt - p0), 64'h0);
    varint_full = 1'b0;

    // Unmapped window, two beats.
    exp_q.push_back(beat(4'hC, RESP_SLVERR, 1'b0, 32'h0));
    exp_q.push_back(beat(4'hC, RESP_SLVERR, 1'b1, 32'h0));
    p0 = pop_cnt;
    ar_req(4'hC, 16'h0900, 8'd1, 3'b010);
    wait_drain("err_drain");
    check("err_no_pop", 64'(pop_cnt - p0), 64'h0);

    // DATA window with a bad size is an error even with data available.
    exp_q.push_back(beat(4'h2, RESP_SLVERR, 1'b1, 32'h0));
    p0 = pop_cnt;
    ar_req(4'h2, 16'h0500, 8'd0, 3'b011);
    wait_drain("badsize_drain");
    check("badsize_no_pop", 64'(pop_cnt - p0), 64'h0);
    fifo_flush();

    // Back-pressure: rready low for 5 cycles on the first beat.
    rready = 1'b0;
    fifo_push(32'hAAA1); fifo_push(32'hAAA2); fifo_push(32'hAAA3); fifo_push(32'hAAA4);
    exp_q.push_back(beat(4'h5, RESP_OKAY, 1'b0, 32'hAAA1));
    exp_q.push_back(beat(4'h5, RESP_OKAY, 1'b0, 32'hAAA2));
    exp_q.push_back(beat(4'h5, RESP_OKAY, 1'b1, 32'hAAA3));
    p0 = pop_cnt;
    ar_req(4'h5, 16'h0500, 8'd2, 3'b010);
    wait_rvalid();
    for (int i = 0; i < 5; i++) begin
      check("stall_rdata",  64'(rdata),  64'hAAA1);
      check("stall_rresp",  64'(rresp),  64'h0);
      check("stall_rlast",  64'(rlast),  64'h0);
      check("stall_rvalid", 64'(rvalid), 64'h1);
      @(negedge clk);
    end
    check("stall_one_pop", 64'(pop_cnt - p0), 64'h1);
    rready = 1'b1;
    wait_drain("stall_drain");
    check("stall_pops", 64'(pop_cnt - p0), 64'h3);

    // Reset while a beat is waiting for rready.
    rready = 1'b0;
    ar_req(4'h6, 16'h0500, 8'd0, 3'b010);
    wait_rvalid();
    check("pre_reset_rdata", 64'(rdata), 64'hAAA4);
    reset = 1'b1;
    @(negedge clk);
    check("reset_rvalid", 64'(rvalid), 64'h0);
    check("reset_state", 64'(state_dbg), 64'(ST_INIT));
    reset = 1'b0;
    check("reinit_clr", 64'(out_fifo_clr), 64'h1);
    @(negedge clk);
    check("reinit_arready", 64'(arready), 64'h1);
    rready = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
